lsu_mem_master: RTL and testbench

// - Load/store initiator between the MEM pipeline stage and the byte-addressed data memory port.
// - Accepts one load/store request at a time. Aligns store data and generates the 4-bit byte-write mask.
// - Drives a req/ack memory handshake, then extracts and sign/zero-extends load data.
// - Optional: splits accesses that cross a word boundary into two word accesses.

---
 rtl/lsu_mem_master_if.sv | 52 +++++
 rtl/lsu_mem_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_master_if
// Bundles the pipeline request/response handshake and the data-memory
// req/ack port of the load/store initiator.
//
// Modports
//   master : the LSU view (accepts requests, returns responses, drives memory)
//   slave  : the environment view (pipeline stage + data memory)
//
// Signals
//   req_valid/req_ready/req_we/req_type/req_addr/req_wdata : pipeline request
//   rsp_valid/rsp_rdata/rsp_err                            : pipeline response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata               : memory access
//   mem_ack/mem_rdata                                      : memory completion
// ----------------------------------------------------------------------------
interface lsu_mem_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_type, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// ----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the MEM pipeline stage and a byte-addressed,
// word-wide data memory. Takes one request at a time, aligns store data and
// builds the byte-lane mask, runs the mem_req/mem_ack handshake, then
// extracts and sign/zero-extends load data.
//
// Ports
//   clk   : rising-edge clock
//   rstn  : asynchronous active-low reset
//   bus   : lsu_mem_master_if.master (request, response and memory signals)
//
// Configuration macro
//   LSU_MISALIGN_SPLIT_EN : when defined, accesses crossing a word boundary
//                           are split into two word accesses; otherwise they
//                           are answered at once with rsp_err = 1.
// ----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    lsu_mem_master_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] ACC1 = 2'd2;
`endif
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic              we_q,        we_d;
    logic [2:0]        type_q,      type_d;
    logic [1:0]        off_q,       off_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_q,     split_d;
    logic [3:0]        be2_q,       be2_d;
    logic [DATA_W-1:0] wdata2_q,    wdata2_d;
    logic [DATA_W-1:0] ldlo_q,      ldlo_d;
`endif

    // ---------------- request decode ----------------
    logic [2:0] size_w;
    logic [3:0] base_w;
    logic       mis_w;

    always_comb begin
        case (bus.req_type)
            3'd1, 3'd2: begin size_w = 3'd2; base_w = 4'b0011; end
            3'd3, 3'd4: begin size_w = 3'd1; base_w = 4'b0001; end
            default:    begin size_w = 3'd4; base_w = 4'b1111; end
        endcase
    end

    assign mis_w = ({1'b0, bus.req_addr[1:0]} + size_w) > 3'd4;

    // Lane-shifted mask/data; in split builds the bits pushed past lane 3
    // are exactly the second-word mask/data.
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]          mask_w;
    logic [2*DATA_W-1:0] wsh_w;
    assign mask_w = {4'b0000, base_w} << bus.req_addr[1:0];
    assign wsh_w  = {{DATA_W{1'b0}}, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
`else
    logic [3:0]          mask_w;
    logic [DATA_W-1:0]   wsh_w;
    assign mask_w = base_w << bus.req_addr[1:0];
    assign wsh_w  = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
`endif

    // ---------------- load data path ----------------
    logic [DATA_W-1:0] raw_w;
    assign raw_w = bus.mem_rdata >> {off_q, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    // second word supplies the bytes above the (4 - off) taken from the first
    logic [DATA_W-1:0] hi_w;
    assign hi_w = bus.mem_rdata << {3'd4 - {1'b0, off_q}, 3'b000};
`endif

    function automatic logic [DATA_W-1:0] extend(input logic [2:0] t,
                                                 input logic [DATA_W-1:0] r);
        case (t)
            3'd1:    return {{(DATA_W-16){r[15]}}, r[15:0]};
            3'd2:    return {{(DATA_W-16){1'b0}},  r[15:0]};
            3'd3:    return {{(DATA_W-8){r[7]}},   r[7:0]};
            3'd4:    return {{(DATA_W-8){1'b0}},   r[7:0]};
            default: return r;
        endcase
    endfunction

    // ---------------- control ----------------
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        type_d      = type_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d     = split_q;
        be2_d       = be2_q;
        wdata2_d    = wdata2_q;
        ldlo_d      = ldlo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    type_d = bus.req_type;
                    off_d  = bus.req_addr[1:0];
`ifndef LSU_MISALIGN_SPLIT_EN
                    if (mis_w) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else
`endif
                    begin
                        state_d     = ACC0;
                        mem_we_d    = bus.req_we;
                        mem_be_d    = mask_w[3:0];
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = wsh_w[DATA_W-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_d     = mis_w;
                        be2_d       = mask_w[7:4];
                        wdata2_d    = wsh_w[2*DATA_W-1:DATA_W];
`endif
                    end
                end
            end
            ACC0: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (bus.mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state_d     = ACC1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_be_d    = be2_q;
                        mem_wdata_d = wdata2_q;
                        ldlo_d      = raw_w;
                    end else
`endif
                    begin
                        state_d     = RESP;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = we_q ? '0 : extend(type_q, raw_w);
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                if (bus.mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : extend(type_q, ldlo_q | hi_w);
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            type_q      <= '0;
            off_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            be2_q       <= '0;
            wdata2_q    <= '0;
            ldlo_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            type_q      <= type_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            be2_q       <= be2_d;
            wdata2_q    <= wdata2_d;
            ldlo_q      <= ldlo_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_master
// Self-checking bench for lsu_mem_master. The bench acts as both pipeline
// and data memory. Expected memory accesses, responses and latencies come
// from a byte-level memory model: each request touches bytes addr..addr+size-1,
// grouped by the word they fall in.
// ----------------------------------------------------------------------------
module tb_lsu_mem_master;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_b [logic [31:0]];
    int          force_delay = -1;
    bit          spurious_en = 1'b0;
    logic [31:0] last_rdata;
    logic [31:0] last_wd0;
    logic        last_err;
    int          last_nacc;
    logic [3:0]  last_be [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_b.exists(a)) return mem_b[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
        for (int unsigned i = 0; i < 4; i++) mem_b[a + i] = w[8*i +: 8];
    endtask

    task automatic run_op(input string name, input logic we, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned size;
        int unsigned off;
        bit          mis, err, done, active;
        int          n_exp, nacc, cyc, dsum, wait_c;
        logic [31:0] exp_addr [2];
        logic [3:0]  exp_be   [2];
        logic [31:0] exp_wd   [2];
        logic [31:0] exp_rd;
        logic [31:0] lmask;
        logic [31:0] r_addr [4];
        logic [3:0]  r_be   [4];
        logic [31:0] r_wd   [4];
        logic        r_we   [4];

        size = (typ == 3'd0) ? 4 : ((typ <= 3'd2) ? 2 : 1);
        off  = addr[1:0];
        mis  = (off + size) > 4;
`ifdef LSU_MISALIGN_SPLIT_EN
        err  = 1'b0;
`else
        err  = mis;
`endif
        n_exp = err ? 0 : (mis ? 2 : 1);
        exp_addr[0] = {addr[31:2], 2'b00};
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_be[0] = '0; exp_be[1] = '0;
        exp_wd[0] = '0; exp_wd[1] = '0;
        exp_rd = '0;
        for (int unsigned i = 0; i < size; i++) begin
            logic [31:0] a;
            int          k;
            a = addr + i;
            k = (a[31:2] == addr[31:2]) ? 0 : 1;
            exp_be[k][a[1:0]] = 1'b1;
            exp_wd[k][8*a[1:0] +: 8] = wdata[8*i +: 8];
            exp_rd[8*i +: 8] = rd_byte(a);
        end
        case (typ)
            3'd1:    exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
            3'd2:    exp_rd = {16'h0, exp_rd[15:0]};
            3'd3:    exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
            3'd4:    exp_rd = {24'h0, exp_rd[7:0]};
            default: ;
        endcase
        if (we || err) exp_rd = '0;

        @(negedge clk);
        check({name, ":ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_type  = typ;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;

        nacc = 0; cyc = 0; dsum = 0; wait_c = 0; done = 1'b0; active = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            // busy-time noise on the request side must be ignored
            bus.req_valid = ($urandom_range(0, 3) == 0);
            bus.req_we    = 1'($urandom);
            bus.req_type  = 3'($urandom_range(0, 4));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.rsp_valid) begin
                done = 1'b1;
                bus.req_valid = 1'b0;
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                check({name, ":lat"}, cyc, err ? 1 : dsum + 2);
                check({name, ":err"}, bus.rsp_err, err);
                check({name, ":rdata"}, bus.rsp_rdata, exp_rd);
            end else if (bus.mem_req) begin
                check({name, ":busy"}, bus.req_ready, 0);
                if (!active) begin
                    if (nacc < 4) begin
                        r_addr[nacc] = bus.mem_addr;
                        r_be[nacc]   = bus.mem_be;
                        r_wd[nacc]   = bus.mem_wdata;
                        r_we[nacc]   = bus.mem_we;
                    end
                    nacc++;
                    active = 1'b1;
                    wait_c = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
                    dsum += wait_c + 1;
                end else if (nacc <= 4) begin
                    check({name, ":hold_addr"},  bus.mem_addr,  r_addr[nacc-1]);
                    check({name, ":hold_be"},    bus.mem_be,    r_be[nacc-1]);
                    check({name, ":hold_wdata"}, bus.mem_wdata, r_wd[nacc-1]);
                    check({name, ":hold_we"},    bus.mem_we,    r_we[nacc-1]);
                end
                if (wait_c == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = {rd_byte(bus.mem_addr + 32'd3), rd_byte(bus.mem_addr + 32'd2),
                                     rd_byte(bus.mem_addr + 32'd1), rd_byte(bus.mem_addr)};
                    active = 1'b0;
                end else begin
                    wait_c--;
                end
            end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        check({name, ":done"}, done, 1);
        check({name, ":nacc"}, nacc, n_exp);
        last_nacc = nacc;
        last_be[0] = '0; last_be[1] = '0;
        for (int k = 0; k < 2; k++) begin
            if (k < nacc && k < n_exp) begin
                last_be[k] = r_be[k];
                check({name, ":maddr"}, r_addr[k], exp_addr[k]);
                check({name, ":mbe"},   r_be[k],   exp_be[k]);
                check({name, ":mwe"},   r_we[k],   we);
                if (we) begin
                    lmask = {{8{exp_be[k][3]}}, {8{exp_be[k][2]}}, {8{exp_be[k][1]}}, {8{exp_be[k][0]}}};
                    check({name, ":mwdata"}, r_wd[k] & lmask, exp_wd[k]);
                end
            end
        end
        last_wd0 = (nacc > 0) ? r_wd[0] : '0;

        @(negedge clk);
        check({name, ":pulse"}, bus.rsp_valid, 0);
        check({name, ":idle"},  bus.req_ready, 1);

        if (we && !err)
            for (int unsigned i = 0; i < size; i++) mem_b[addr + i] = wdata[8*i +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_type  = 3'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",     bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err",   bus.rsp_err,   0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_mem_req",   bus.mem_req,   0);
        check("rst_mem_we",    bus.mem_we,    0);
        check("rst_mem_be",    bus.mem_be,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        rstn = 1'b1;

        force_delay = 0;
        run_op("sb", 1'b1, 3'd3, 32'h1001, 32'h0000_00AB);
        check("sb_wdata_full", last_wd0, 32'h0000_AB00);

        preload_word(32'h1000, 32'h80FF_FFFF);
        run_op("lb", 1'b0, 3'd3, 32'h1003, 32'h0);
        check("lb_val", last_rdata, 32'hFFFF_FF80);
        run_op("lbu", 1'b0, 3'd4, 32'h1003, 32'h0);
        check("lbu_val", last_rdata, 32'h0000_0080);

        preload_word(32'h1000, 32'h8001_1234);
        run_op("lh", 1'b0, 3'd1, 32'h1002, 32'h0);
        check("lh_val", last_rdata, 32'hFFFF_8001);
        run_op("lhu", 1'b0, 3'd2, 32'h1000, 32'h0);
        check("lhu_val", last_rdata, 32'h0000_1234);

        preload_word(32'h1000, 32'h4433_2211);
        preload_word(32'h1004, 32'h8877_6655);
        run_op("lw_mis", 1'b0, 3'd0, 32'h1002, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("lw_mis_val", last_rdata, 32'h6655_4433);
        check("lw_mis_be0", last_be[0], 4'b1100);
        check("lw_mis_be1", last_be[1], 4'b0011);
`else
        check("lw_mis_err",  last_err,  1);
        check("lw_mis_nacc", last_nacc, 0);
`endif

        force_delay = 3;
        run_op("sw_wait", 1'b1, 3'd0, 32'h1000, 32'h1234_5678);
        force_delay = -1;

        // reset while an access is outstanding
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_type  = 3'd0;
        bus.req_addr  = 32'h1000;
        bus.req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_mreq_before", bus.mem_req, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_mreq_async", bus.mem_req,   0);
        check("rst_mid_ready",      bus.req_ready, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("rst_mid_norsp", seen, 0);
        run_op("rst_next_sw", 1'b1, 3'd0, 32'h1000, 32'hCAFE_F00D);

        spurious_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                            a = 32'h1000 + 32'($urandom_range(0, 63));
            run_op("rnd", 1'($urandom), 3'($urandom_range(0, 4)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
